mem_stage: RTL

- MEM stage of the 5-stage MIPS pipeline, sitting directly downstream of the EX/MEM latch.
- Holds the data memory: sized stores and sized, sign- or zero-extended loads.
- Resolves beq/bne into the PC-select signal for IF.
- Provides a registered debug read port for the debug unit, and a sticky misalignment flag.

---
 rtl/mem_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MEM stage: data memory with sized loads/stores, branch resolve,
// registered debug read port and sticky misalignment flag.
module mem_stage #(
    parameter int BITS_SIZE = 32,
    parameter int MEM_DEPTH = 256,
    parameter int BITS_ADDR = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_step,
    input  logic [BITS_SIZE-1:0] i_alu,
    input  logic [BITS_SIZE-1:0] i_register_2,
    input  logic                 i_zero,
    input  logic [BITS_SIZE-1:0] i_pc_branch,
    input  logic                 i_branch,
    input  logic                 i_neq_branch,
    input  logic                 i_mem_write,
    input  logic                 i_mem_read,
    input  logic [1:0]           i_datamem_size,
    input  logic [1:0]           i_data_load_size,
    input  logic                 i_zero_extend,
    input  logic [BITS_ADDR-1:0] i_debug_addr,
    output logic [BITS_SIZE-1:0] o_mem_data,
    output logic                 o_pc_src,
    output logic [BITS_SIZE-1:0] o_pc_branch,
    output logic [BITS_SIZE-1:0] o_debug_data,
    output logic                 o_misaligned
);

    localparam int LANES = BITS_SIZE / 8;

    logic [BITS_SIZE-1:0] mem [MEM_DEPTH];

    logic [BITS_ADDR-1:0] idx;
    logic [1:0]           off;
    logic [BITS_SIZE-1:0] word;
    logic [BITS_SIZE-1:0] shifted;
    logic                 st_mis;
    logic                 ld_mis;
    logic [LANES-1:0]     be;
    logic [BITS_SIZE-1:0] wdata;
    logic                 do_write;
    logic                 mis_set;
    logic                 unused_bits;

    // Upper address bits wrap the index; they are intentionally dropped.
    assign unused_bits = ^i_alu[BITS_SIZE-1:BITS_ADDR+2];

    assign idx     = i_alu[BITS_ADDR+1:2];
    assign off     = i_alu[1:0];
    assign word    = mem[idx];
    assign shifted = word >> {off, 3'b000};

    assign o_pc_branch = i_pc_branch;
    assign o_pc_src    = (i_branch & i_zero) | (i_neq_branch & ~i_zero);

    // Alignment check for store and load sizes.
    always_comb begin
        st_mis = 1'b0;
        ld_mis = 1'b0;
        unique case (i_datamem_size)
            2'b00:   st_mis = 1'b0;
            2'b01:   st_mis = off[0];
            default: st_mis = (off != 2'b00);
        endcase
        unique case (i_data_load_size)
            2'b00:   ld_mis = 1'b0;
            2'b01:   ld_mis = off[0];
            default: ld_mis = (off != 2'b00);
        endcase
    end

    // Lane enables; data is replicated so every lane sees its bytes.
    always_comb begin
        be    = '0;
        wdata = i_register_2;
        unique case (i_datamem_size)
            2'b00: begin
                be    = {{(LANES-1){1'b0}}, 1'b1} << off;
                wdata = {LANES{i_register_2[7:0]}};
            end
            2'b01: begin
                be    = {{(LANES-2){1'b0}}, 2'b11} << off;
                wdata = {(LANES/2){i_register_2[15:0]}};
            end
            default: begin
                be    = '1;
                wdata = i_register_2;
            end
        endcase
    end

    assign do_write = i_step & i_mem_write & ~st_mis;
    assign mis_set  = i_step & ((i_mem_write & st_mis) |
                                (i_mem_read & ld_mis));

    // Load extraction with sign or zero extension.
    always_comb begin
        o_mem_data = '0;
        if (i_mem_read && !ld_mis) begin
            unique case (i_data_load_size)
                2'b00: o_mem_data = i_zero_extend ?
                    {{(BITS_SIZE-8){1'b0}}, shifted[7:0]} :
                    {{(BITS_SIZE-8){shifted[7]}}, shifted[7:0]};
                2'b01: o_mem_data = i_zero_extend ?
                    {{(BITS_SIZE-16){1'b0}}, shifted[15:0]} :
                    {{(BITS_SIZE-16){shifted[15]}}, shifted[15:0]};
                default: o_mem_data = word;
            endcase
        end
    end

    // Data memory: cleared on reset, byte-lane writes when stepping.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            for (int b = 0; b < LANES; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Debug read: old data on a same-edge store, never gated by step.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_debug_data <= '0;
        end else begin
            o_debug_data <= mem[i_debug_addr];
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_misaligned <= 1'b0;
        end else if (mis_set) begin
            o_misaligned <= 1'b1;
        end
    end

endmodule
